// File: rtl/gray_counter_param.sv
// -----------------------------------------------------------------------------
// gray_counter_param
//
// Parametrised up/down Gray code counter with synchronous load, count enable
// and a selectable wrap or saturate behaviour at the numeric boundaries.
//
// The counter keeps a binary state register and a Gray output register.
// Both are loaded from the same "next binary" value on every edge, so the
// Gray output is always exactly bin ^ (bin >> 1). There is never a cycle in
// which the Gray output lags the binary count.
//
// Intended as the shared counter primitive for async FIFO pointers and
// position encoders.
//
// Parameters
//   WIDTH     : counter width in bits, legal range 2..32 (default 8)
//   SATURATE  : 0 = wrap at the boundaries, 1 = hold at the boundaries
//   RESET_VAL : binary value loaded on reset, must be < 2^WIDTH
//
// Ports
//   clk       in   1      clock, all state changes on the rising edge
//   rst       in   1      synchronous reset, active-high
//   en        in   1      count enable, one step per enabled cycle
//   up_dn     in   1      direction, 1 = increment, 0 = decrement
//   load      in   1      synchronous load strobe
//   load_val  in   WIDTH  binary value to load
//   bin       out  WIDTH  registered binary count
//   gray      out  WIDTH  registered Gray code of bin
//   tc        out  1      registered one-cycle terminal-count pulse
//
// Optional feature (compile-time macro GRAY_MATCH_EN)
//   match_val in   WIDTH  Gray-coded compare value
//   match     out  1      registered, high in the cycle after an edge whose
//                         next Gray value equals match_val
//   With GRAY_MATCH_EN undefined these ports and the comparator do not exist.
//
// Edge priority: rst > load > en > hold.
// A boundary step is a step attempted at all-ones going up or at all-zeros
// going down. It raises tc for the following cycle. With SATURATE=0 the
// counter wraps. With SATURATE=1 the counter holds its value. Every other
// edge clears tc.
// -----------------------------------------------------------------------------
module gray_counter_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef GRAY_MATCH_EN
    input  logic [WIDTH-1:0] match_val,
`endif
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc
`ifdef GRAY_MATCH_EN
    ,
    output logic             match
`endif
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] RESET_BIN = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_BIN   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};
    localparam bit               SAT_EN    = (SATURATE != 32'd0);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Binary to reflected Gray code: each bit XORs with its more-significant neighbour.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ {1'b0, b[WIDTH-1:1]};
    endfunction

    localparam logic [WIDTH-1:0] RESET_GRAY = bin2gray(RESET_BIN);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             tc_r;

    // -------------------------------------------------------------------------
    // Next-state signals
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] inc_s;
    logic [WIDTH-1:0] dec_s;
    logic             at_max_s;
    logic             at_min_s;
    logic             boundary_s;
    logic [WIDTH-1:0] bin_next_s;
    logic [WIDTH-1:0] gray_next_s;
    logic             tc_next_s;

    // Step candidates and boundary detection from the current binary count.
    always_comb begin
        inc_s    = bin_r + ONE_BIN;
        dec_s    = bin_r - ONE_BIN;
        at_max_s = (bin_r == ALL_ONES);
        at_min_s = (bin_r == ALL_ZEROS);
        if (up_dn) begin
            boundary_s = at_max_s;
        end else begin
            boundary_s = at_min_s;
        end
    end

    // Next binary value and terminal-count decision, with load over count over hold.
    always_comb begin
        bin_next_s = bin_r;
        tc_next_s  = 1'b0;
        if (load) begin
            bin_next_s = load_val;
            tc_next_s  = 1'b0;
        end else if (en) begin
            if (boundary_s) begin
                // Boundary step: always flag it. In saturate mode the count is held.
                tc_next_s = 1'b1;
                if (SAT_EN) begin
                    bin_next_s = bin_r;
                end else if (up_dn) begin
                    bin_next_s = inc_s;
                end else begin
                    bin_next_s = dec_s;
                end
            end else begin
                tc_next_s = 1'b0;
                if (up_dn) begin
                    bin_next_s = inc_s;
                end else begin
                    bin_next_s = dec_s;
                end
            end
        end else begin
            bin_next_s = bin_r;
            tc_next_s  = 1'b0;
        end
    end

    // The Gray register is fed from the next binary value so both update on the same edge.
    always_comb begin
        gray_next_s = bin2gray(bin_next_s);
    end

    // Counter state registers with synchronous reset overriding load and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r  <= RESET_BIN;
            gray_r <= RESET_GRAY;
            tc_r   <= 1'b0;
        end else begin
            bin_r  <= bin_next_s;
            gray_r <= gray_next_s;
            tc_r   <= tc_next_s;
        end
    end

    assign bin  = bin_r;
    assign gray = gray_r;
    assign tc   = tc_r;

`ifdef GRAY_MATCH_EN
    logic match_r;
    logic match_next_s;

    // Compare against the Gray value being written this edge, so match lines up with gray.
    always_comb begin
        match_next_s = (gray_next_s == match_val);
    end

    // Registered match flag, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_r <= 1'b0;
        end else begin
            match_r <= match_next_s;
        end
    end

    assign match = match_r;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// -----------------------------------------------------------------------------
// tb_gray_counter_param
//
// Directed testbench for gray_counter_param. Four instances share one set of
// stimulus inputs:
//   a : WIDTH=4, SATURATE=0, RESET_VAL=0
//   b : WIDTH=4, SATURATE=1, RESET_VAL=0
//   c : WIDTH=4, SATURATE=0, RESET_VAL=3
//   m : WIDTH=8, SATURATE=0, RESET_VAL=0 (match port exercised under GRAY_MATCH_EN)
// Expected results are queued when the stimulus for an edge is set up. They
// are popped and compared 1 ns after that rising edge.
// -----------------------------------------------------------------------------
module tb_gray_counter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] match_val;

    logic [3:0] bin_a, gray_a, bin_b, gray_b, bin_c, gray_c;
    logic       tc_a, tc_b, tc_c;
    logic [7:0] bin_m, gray_m;
    logic       tc_m;
    logic       match_m;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        int         dut;
        logic [7:0] b;
        logic [7:0] g;
        logic       t;
        logic       m;
        string      tag;
    } exp_t;

    exp_t sb[$];

    logic [3:0] gtab [0:16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(4), .SATURATE(0), .RESET_VAL(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[3:0]),
`ifdef GRAY_MATCH_EN
        .match_val(match_val[3:0]), .match(),
`endif
        .bin(bin_a), .gray(gray_a), .tc(tc_a)
    );

    gray_counter_param #(.WIDTH(4), .SATURATE(1), .RESET_VAL(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[3:0]),
`ifdef GRAY_MATCH_EN
        .match_val(match_val[3:0]), .match(),
`endif
        .bin(bin_b), .gray(gray_b), .tc(tc_b)
    );

    gray_counter_param #(.WIDTH(4), .SATURATE(0), .RESET_VAL(3)) dut_c (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[3:0]),
`ifdef GRAY_MATCH_EN
        .match_val(match_val[3:0]), .match(),
`endif
        .bin(bin_c), .gray(gray_c), .tc(tc_c)
    );

    gray_counter_param #(.WIDTH(8), .SATURATE(0), .RESET_VAL(0)) dut_m (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val),
`ifdef GRAY_MATCH_EN
        .match_val(match_val), .match(match_m),
`endif
        .bin(bin_m), .gray(gray_m), .tc(tc_m)
    );

`ifndef GRAY_MATCH_EN
    assign match_m = 1'b0;
`endif

    task automatic push(input int d, input logic [7:0] b, input logic [7:0] g,
                        input logic t, input logic m, input string tag);
        exp_t e;
        e.dut = d;
        e.b   = b;
        e.g   = g;
        e.t   = t;
        e.m   = m;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic l, input logic e,
                         input logic u, input logic [7:0] lv);
        rst      = r;
        load     = l;
        en       = e;
        up_dn    = u;
        load_val = lv;
    endtask

    // Advance one edge, then compare every queued expectation for it.
    task automatic tick();
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] ob;
            logic [7:0] og;
            logic       ot;
            e = sb.pop_front();
            case (e.dut)
                0: begin ob = {4'h0, bin_a}; og = {4'h0, gray_a}; ot = tc_a; end
                1: begin ob = {4'h0, bin_b}; og = {4'h0, gray_b}; ot = tc_b; end
                2: begin ob = {4'h0, bin_c}; og = {4'h0, gray_c}; ot = tc_c; end
                default: begin ob = bin_m; og = gray_m; ot = tc_m; end
            endcase
            n_asserts++;
            assert (ob === e.b) else begin
                n_fail++;
                $error("FAIL %s.bin observed=%0h expected=%0h", e.tag, ob, e.b);
            end
            n_asserts++;
            assert (og === e.g) else begin
                n_fail++;
                $error("FAIL %s.gray observed=%0h expected=%0h", e.tag, og, e.g);
            end
            n_asserts++;
            assert (ot === e.t) else begin
                n_fail++;
                $error("FAIL %s.tc observed=%0b expected=%0b", e.tag, ot, e.t);
            end
`ifdef GRAY_MATCH_EN
            if (e.dut == 3) begin
                n_asserts++;
                assert (match_m === e.m) else begin
                    n_fail++;
                    $error("FAIL %s.match observed=%0b expected=%0b", e.tag, match_m, e.m);
                end
            end
`endif
        end
    endtask

    initial begin
        logic [3:0] prev_g;
        logic [7:0] gi;
        match_val = 8'h0C;

        // Reset state of every instance.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        push(0, 8'h0, 8'h0, 1'b0, 1'b0, "rst_a");
        push(1, 8'h0, 8'h0, 1'b0, 1'b0, "rst_b");
        push(2, 8'h3, 8'h2, 1'b0, 1'b0, "rst_c");
        push(3, 8'h0, 8'h0, 1'b0, 1'b0, "rst_m");
        tick();

        // Full up-count with wrap: Gray sequence, tc only on the wrap, Hamming distance 1.
        prev_g = gray_a;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            push(0, 8'(i % 16), {4'h0, gtab[i]}, (i == 16), 1'b0, "up_seq");
            tick();
            n_asserts++;
            assert ($countones(gray_a ^ prev_g) === 1) else begin
                n_fail++;
                $error("FAIL hamming step %0d observed=%0h->%0h expected one-bit change", i, prev_g, gray_a);
            end
            prev_g = gray_a;
        end

        // Down from reset wraps to max, then a normal down step, then hold.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        push(0, 8'h0, 8'h0, 1'b0, 1'b0, "rst2_a");
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        push(0, 8'hF, 8'h8, 1'b1, 1'b0, "dn_wrap");
        push(2, 8'h2, 8'h3, 1'b0, 1'b0, "dn_c");
        tick();
        push(0, 8'hE, 8'h9, 1'b0, 1'b0, "dn_step");
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        push(0, 8'hE, 8'h9, 1'b0, 1'b0, "hold");
        tick();

        // Saturate at max: load F, push up three times, then step back down.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h0F);
        push(1, 8'hF, 8'h8, 1'b0, 1'b0, "sat_load");
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(1, 8'hF, 8'h8, 1'b1, 1'b0, "sat_up1");
        push(0, 8'h0, 8'h0, 1'b1, 1'b0, "wrap_up");
        tick();
        push(1, 8'hF, 8'h8, 1'b1, 1'b0, "sat_up2");
        tick();
        push(1, 8'hF, 8'h8, 1'b1, 1'b0, "sat_up3");
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        push(1, 8'hE, 8'h9, 1'b0, 1'b0, "sat_rev");
        tick();

        // Load wins over enable, then counting resumes from the loaded value.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h0A);
        push(0, 8'hA, 8'hF, 1'b0, 1'b0, "load_pri");
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 8'hB, 8'hE, 1'b0, 1'b0, "load_next");
        tick();

        // Reset mid-count with load and enable asserted: RESET_VAL=3 wins.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        push(2, 8'h3, 8'h2, 1'b0, 1'b0, "rst3_c");
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(2, 8'h4, 8'h6, 1'b0, 1'b0, "c_up4");
        tick();
        push(2, 8'h5, 8'h7, 1'b0, 1'b0, "c_up5");
        tick();
        push(2, 8'h6, 8'h5, 1'b0, 1'b0, "c_up6");
        tick();
        push(2, 8'h7, 8'h4, 1'b0, 1'b0, "c_up7");
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h09);
        push(2, 8'h3, 8'h2, 1'b0, 1'b0, "rst_mid");
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(2, 8'h4, 8'h6, 1'b0, 1'b0, "rst_resume");
        tick();

        // Saturate at zero going down, tc clears on hold, reverse is a normal step.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        push(1, 8'h0, 8'h0, 1'b0, 1'b0, "rst4_b");
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        push(1, 8'h0, 8'h0, 1'b1, 1'b0, "sat_dn1");
        tick();
        push(1, 8'h0, 8'h0, 1'b1, 1'b0, "sat_dn2");
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        push(1, 8'h0, 8'h0, 1'b0, 1'b0, "sat_hold");
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(1, 8'h1, 8'h1, 1'b0, 1'b0, "sat_rev0");
        tick();

        // 8-bit up-count; match (when built) fires only at gray=0C (bin=08).
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        push(3, 8'h00, 8'h00, 1'b0, 1'b0, "rst_m2");
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            gi = 8'(i);
            push(3, gi, gi ^ (gi >> 1), 1'b0, (i == 8), "m_up");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
